// File: rtl/life_ctrl_if.sv
// ---------------------------------------------------------------------------
// life_ctrl_if
// Bus between the lives controller and the 4-bit lives down-counter.
//   ld_n   controller -> counter  parallel load strobe, active-low
//   d      controller -> counter  load value, meaningful while ld_n=0
//   ctp    controller -> counter  count enable P, one-cycle decrement pulse
//   ctt    controller -> counter  count enable T, always equal to ctp
//   cnt_q  counter -> controller  current counter Q
// Modports: master = controller side, slave = counter side.
// ---------------------------------------------------------------------------
interface life_ctrl_if #(
  parameter int W = 4
);
  logic         ld_n;
  logic [W-1:0] d;
  logic         ctp;
  logic         ctt;
  logic [W-1:0] cnt_q;

  modport master (
    output ld_n,
    output d,
    output ctp,
    output ctt,
    input  cnt_q
  );

  modport slave (
    input  ld_n,
    input  d,
    input  ctp,
    input  ctt,
    output cnt_q
  );
endinterface

// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl
// Control stage in front of the lives down-counter. Synchronises and debounces
// the ball-miss and start inputs, issues one decrement pulse per miss and a
// preset load on game start, and watches the counter's Q to detect game over
// and to keep the counter from wrapping below zero.
//
// Optional feature macro: LIFE_BONUS_EN
//   When defined, adds bonus_in; a debounced bonus rise in PLAY loads
//   min(Q+1, MAX_LIVES). A bonus rise seen in HIT is remembered (one deep)
//   and applied on the return to PLAY.
//
// Ports
//   CP         in   clock, rising edge
//   CR         in   asynchronous active-low reset
//   miss_in    in   ball-missed level, asynchronous
//   start_in   in   start button, asynchronous and bouncy
//   bonus_in   in   bonus-life request (LIFE_BONUS_EN only)
//   cbus       master modport of life_ctrl_if (ld_n, d, ctp, ctt out; cnt_q in)
//   game_over  out  high in OVER
//   playing    out  high in PLAY and HIT
// All outputs are registered.
// ---------------------------------------------------------------------------
module life_ctrl #(
  parameter int W          = 4,
  parameter int INIT_LIVES = 5,
  parameter int MAX_LIVES  = 9,
  parameter int DEB_CYC    = 16
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        miss_in,
  input  logic        start_in,
`ifdef LIFE_BONUS_EN
  input  logic        bonus_in,
`endif
  life_ctrl_if.master cbus,
  output logic        game_over,
  output logic        playing
);

  // Input channel indices into the shared sync/debounce vectors.
  localparam int MISS  = 0;
  localparam int START = 1;
`ifdef LIFE_BONUS_EN
  localparam int BONUS = 2;
  localparam int NIN   = 3;
`else
  localparam int NIN   = 2;
`endif

  localparam int           CW       = $clog2(DEB_CYC);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [W-1:0]  INIT_V   = W'(INIT_LIVES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  logic [NIN-1:0]         raw;
  logic [NIN-1:0]         sync1;
  logic [NIN-1:0]         sync2;
  logic [NIN-1:0]         deb;
  logic [NIN-1:0]         deb_d;
  logic [NIN-1:0][CW-1:0] deb_cnt;
  logic [NIN-1:0]         rise;

  state_t       state;
  state_t       state_nx;
  logic         ld_n_q;
  logic         ld_n_nx;
  logic [W-1:0] d_q;
  logic [W-1:0] d_nx;
  logic         ctp_q;
  logic         ctp_nx;
  logic         game_over_q;
  logic         playing_q;

  logic         miss_rise;
  logic         start_rise;
  logic         miss_lvl;
  logic [W-1:0] eff_q;
  logic         cnt_zero;
  logic         cancel;
  logic         bonus_req;
  logic [W-1:0] bonus_d;

`ifdef LIFE_BONUS_EN
  assign raw = {bonus_in, start_in, miss_in};
`else
  assign raw = {start_in, miss_in};
`endif

  // Two-flop synchroniser followed by a per-input debounce counter. The
  // counter only runs while the synchronised level differs from the accepted
  // level; any return to the accepted level (i.e. any bounce) clears it, so a
  // new level is accepted only after DEB_CYC consecutive stable samples.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_d   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise       = deb & ~deb_d;
  assign miss_rise  = rise[MISS];
  assign start_rise = rise[START];
  assign miss_lvl   = deb[MISS];

  // The counter only reflects a load or decrement one edge after we issue it.
  // While a load is in flight its value is already known (d_q); while a
  // decrement is in flight Q is stale, so the zero check is skipped.
  assign eff_q    = ld_n_q ? cbus.cnt_q : d_q;
  assign cnt_zero = ~ctp_q & (eff_q == '0);

`ifdef LIFE_BONUS_EN
  logic         pend;
  logic [W:0]   bonus_sum;
  localparam logic [W:0]   MAX_X = (W+1)'(MAX_LIVES);
  localparam logic [W-1:0] MAX_V = W'(MAX_LIVES);

  // Sum at W+1 bits so Q=15 cannot wrap before saturation.
  assign bonus_sum = {1'b0, eff_q} + {{W{1'b0}}, 1'b1};
  assign bonus_d   = (bonus_sum > MAX_X) ? MAX_V : bonus_sum[W-1:0];
  assign cancel    = miss_rise & rise[BONUS];
  assign bonus_req = rise[BONUS] | pend;

  // One-deep memory for a bonus that arrives while a miss is being held.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      pend <= 1'b0;
    end else if ((state_nx == OVER) || ((state == PLAY) && !ld_n_nx)) begin
      pend <= 1'b0;
    end else if ((state == HIT) && rise[BONUS]) begin
      pend <= 1'b1;
    end
  end
`else
  assign bonus_d   = d_q;
  assign cancel    = 1'b0;
  assign bonus_req = 1'b0;
`endif

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state       <= IDLE;
      ld_n_q      <= 1'b1;
      d_q         <= INIT_V;
      ctp_q       <= 1'b0;
      game_over_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      ld_n_q      <= ld_n_nx;
      d_q         <= d_nx;
      ctp_q       <= ctp_nx;
      game_over_q <= (state_nx == OVER);
      playing_q   <= (state_nx == PLAY) || (state_nx == HIT);
    end
  end

  // Load and decrement sit in mutually exclusive branches, so ld_n=0 and
  // ctp=1 can never be issued together.
  always_comb begin
    state_nx = state;
    ld_n_nx  = 1'b1;
    ctp_nx   = 1'b0;
    d_nx     = d_q;
    unique case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          ld_n_nx  = 1'b0;
          d_nx     = INIT_V;
          state_nx = PLAY;
        end
      end
      PLAY: begin
        if (cancel) begin
          state_nx = PLAY;
        end else if (miss_rise) begin
          if (cnt_zero) begin
            state_nx = OVER;
          end else begin
            ctp_nx   = 1'b1;
            state_nx = HIT;
          end
        end else if (cnt_zero) begin
          state_nx = OVER;
        end else if (bonus_req) begin
          ld_n_nx = 1'b0;
          d_nx    = bonus_d;
        end
      end
      HIT: begin
        if (cnt_zero) begin
          state_nx = OVER;
        end else if (!miss_lvl) begin
          state_nx = PLAY;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign cbus.ld_n = ld_n_q;
  assign cbus.d    = d_q;
  assign cbus.ctp  = ctp_q;
  assign cbus.ctt  = ctp_q;
  assign game_over = game_over_q;
  assign playing   = playing_q;

endmodule
